// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus: FU index map, default widths, payload type.
// The optional per-lane kill input of cdb_arbiter is enabled with the CDB_FLUSH_EN macro.
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_ADDR_W = 5;

  // FU index i drives arbiter lane i-1; CDB_result bit i names FU index i.
  localparam int ALU  = 1;
  localparam int MEM  = 2;
  localparam int MUL  = 3;
  localparam int DIV  = 4;
  localparam int JUMP = 5;
  localparam int ALU2 = 6;
  localparam int MEM2 = 7;
  localparam int MUL2 = 8;

  typedef struct packed {
    logic                  valid;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_ADDR_W-1:0] addr;
    logic                  wb;
  } cdb_payload_t;

  function automatic int fu_lane(input int fu_index);
    return fu_index - 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first requesting lane at or after ptr, wrapping.
// Generic in N so the issue-port arbiter can reuse it.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] lane;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    lane  = '0;
    for (int off = 0; off < N; off++) begin
      lane = IDX_W'((int'(ptr) + off) % N);
      if (!valid && req[lane]) begin
        valid       = 1'b1;
        grant[lane] = 1'b1;
        idx         = lane;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback stage: one holding slot per FU, round-robin broadcast of one slot per cycle.
// Define CDB_FLUSH_EN to add the flush_mask input that kills speculative slots.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FU_NUM = 8,
  parameter int DATA_W = CDB_DATA_W,
  parameter int ADDR_W = CDB_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FU_NUM-1:0]        fu_valid,
  output logic [FU_NUM-1:0]        fu_ready,
  input  logic [FU_NUM*DATA_W-1:0] fu_data,
  input  logic [FU_NUM*ADDR_W-1:0] fu_rd,
  input  logic [FU_NUM-1:0]        fu_wb,
`ifdef CDB_FLUSH_EN
  input  logic [FU_NUM-1:0]        flush_mask,
`endif
  output logic                     CDB_valid,
  output logic [DATA_W-1:0]        CDB_data,
  output logic [ADDR_W-1:0]        CDB_addr,
  output logic [FU_NUM:0]          CDB_result,
  output logic                     register_write_en
);

  localparam int IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  // Handshake: a result moves into slot k on a rising edge where fu_valid[k] & fu_ready[k].
  // The FU must hold fu_valid and its payload stable until that edge.
  logic [FU_NUM-1:0] full;
  logic [DATA_W-1:0] slot_data [FU_NUM];
  logic [ADDR_W-1:0] slot_rd   [FU_NUM];
  logic [FU_NUM-1:0] slot_wb;
  logic [IDX_W-1:0]  rr_ptr;

  logic [FU_NUM-1:0] grant;
  logic [IDX_W-1:0]  win_idx;
  logic              any_req;
  logic              grant_ok;
  logic [FU_NUM-1:0] kill;
  logic [FU_NUM-1:0] accept;
  logic              cdb_wb;

  rr_arbiter #(
    .N     (FU_NUM),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (full),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .valid (any_req)
  );

`ifdef CDB_FLUSH_EN
  assign kill = flush_mask;
`else
  assign kill = '0;
`endif

  // A killed winner produces no broadcast and leaves the pointer where it was.
  assign grant_ok = any_req & ~|(grant & kill);
  assign fu_ready = ~full | grant | kill;
  assign accept   = fu_valid & fu_ready & ~kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      slot_wb <= '0;
      for (int k = 0; k < FU_NUM; k++) begin
        slot_data[k] <= '0;
        slot_rd[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < FU_NUM; k++) begin
        if (kill[k]) begin
          full[k] <= 1'b0;
        end else if (accept[k]) begin
          full[k]      <= 1'b1;
          slot_data[k] <= fu_data[k*DATA_W +: DATA_W];
          slot_rd[k]   <= fu_rd[k*ADDR_W +: ADDR_W];
          slot_wb[k]   <= fu_wb[k];
        end else if (grant[k] && grant_ok) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  // Data and address hold their last broadcast value on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CDB_valid  <= 1'b0;
      CDB_data   <= '0;
      CDB_addr   <= '0;
      CDB_result <= '0;
      cdb_wb     <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      CDB_valid  <= grant_ok;
      CDB_result <= '0;
      if (grant_ok) begin
        CDB_data   <= slot_data[win_idx];
        CDB_addr   <= slot_rd[win_idx];
        cdb_wb     <= slot_wb[win_idx];
        CDB_result <= {grant, 1'b0};
        rr_ptr     <= (win_idx == IDX_W'(FU_NUM - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

  assign register_write_en = CDB_valid & cdb_wb & (CDB_addr != '0);

endmodule
